// File: rtl/pipeline_idc_queue_pkg.sv
// Shared types and constants for the IDC bundle queue: field widths, the decoded
// bundle payload, opcode/ALU encodings and small decode helpers.
package pipeline_idc_pkg;

  localparam int unsigned REG_W      = 5;
  localparam int unsigned ALU_CTRL_W = 4;
  localparam int unsigned BR_W       = 3;
  localparam int unsigned WR_SEL_W   = 2;
  localparam int unsigned DM_CTRL_W  = 3;
  // pc/imm are carried at the widest supported XLEN; the queue truncates on output
  localparam int unsigned IDC_XLEN   = 64;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD   = 4'd0;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB   = 4'd1;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL   = 4'd2;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT   = 4'd3;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU  = 4'd4;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR   = 4'd5;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL   = 4'd6;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA   = 4'd7;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR    = 4'd8;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND   = 4'd9;
  localparam logic [ALU_CTRL_W-1:0] ALU_COPYB = 4'd10;

  localparam logic [WR_SEL_W-1:0] WB_NONE = 2'd0;
  localparam logic [WR_SEL_W-1:0] WB_ALU  = 2'd1;
  localparam logic [WR_SEL_W-1:0] WB_MEM  = 2'd2;
  localparam logic [WR_SEL_W-1:0] WB_PC4  = 2'd3;

  typedef struct packed {
    logic [REG_W-1:0]      rd;
    logic [REG_W-1:0]      rs1;
    logic [REG_W-1:0]      rs2;
    logic [IDC_XLEN-1:0]   imm;
    logic [IDC_XLEN-1:0]   pc;
    logic                  rf_wr_en;
    logic                  do_jump;
    logic                  is_branch;
    logic                  is_debug;
    logic                  alu_a_sel;
    logic                  alu_b_sel;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic [BR_W-1:0]       br_type;
    logic [WR_SEL_W-1:0]   rf_wr_sel;
    logic [DM_CTRL_W-1:0]  dm_rd_ctrl;
    logic [DM_CTRL_W-1:0]  dm_wr_ctrl;
  } idc_bundle_t;

  localparam idc_bundle_t IDC_BUBBLE = '0;

  // ALU op from funct3; alt selects SUB/SRA
  function automatic logic [ALU_CTRL_W-1:0] alu_op(input logic [2:0] funct3, input logic alt);
    logic [ALU_CTRL_W-1:0] op;
    op = ALU_ADD;
    case (funct3)
      3'b000: op = alt ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = alt ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Branch type: 0 none, 1 beq, 2 bne, 3 blt, 4 bge, 5 bltu, 6 bgeu
  function automatic logic [BR_W-1:0] br_type_of(input logic [2:0] funct3);
    logic [BR_W-1:0] bt;
    bt = '0;
    case (funct3)
      3'b000: bt = 3'd1;
      3'b001: bt = 3'd2;
      3'b100: bt = 3'd3;
      3'b101: bt = 3'd4;
      3'b110: bt = 3'd5;
      3'b111: bt = 3'd6;
      default: bt = '0;
    endcase
    return bt;
  endfunction

endpackage

// File: rtl/pipeline_idc_queue_decode.sv
// Instruction decode for the IDC queue: imm (immediate generator), ctrl (control
// decoder) and idc_decode, which packs both into an idc_bundle_t.
import pipeline_idc_pkg::*;

module imm (
  input  logic [31:0] inst,
  output logic [63:0] out
);

  // Sign-extended immediate selected by instruction format
  always_comb begin
    out = '0;
    case (inst[6:0])
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:
        out = {{52{inst[31]}}, inst[31:20]};
      OP_STORE:
        out = {{52{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH:
        out = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        out = {{32{inst[31]}}, inst[31:12], 12'b0};
      OP_JAL:
        out = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:
        out = '0;
    endcase
  end

endmodule

module ctrl (
  input  logic [31:0]           inst,
  output logic                  rf_wr_en,
  output logic                  do_jump,
  output logic                  is_branch,
  output logic                  is_debug,
  output logic                  alu_a_sel,
  output logic                  alu_b_sel,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic [BR_W-1:0]       br_type,
  output logic [WR_SEL_W-1:0]   rf_wr_sel,
  output logic [DM_CTRL_W-1:0]  dm_rd_ctrl,
  output logic [DM_CTRL_W-1:0]  dm_wr_ctrl
);

  logic [2:0] funct3;
  assign funct3 = inst[14:12];

  // Control signals per opcode; alu_a_sel=1 picks pc, alu_b_sel=1 picks imm
  always_comb begin
    rf_wr_en   = 1'b0;
    do_jump    = 1'b0;
    is_branch  = 1'b0;
    is_debug   = 1'b0;
    alu_a_sel  = 1'b0;
    alu_b_sel  = 1'b0;
    alu_ctrl   = ALU_ADD;
    br_type    = '0;
    rf_wr_sel  = WB_NONE;
    dm_rd_ctrl = '0;
    dm_wr_ctrl = '0;
    case (inst[6:0])
      OP_LUI: begin
        rf_wr_en = 1'b1; alu_b_sel = 1'b1; alu_ctrl = ALU_COPYB; rf_wr_sel = WB_ALU;
      end
      OP_AUIPC: begin
        rf_wr_en = 1'b1; alu_a_sel = 1'b1; alu_b_sel = 1'b1; rf_wr_sel = WB_ALU;
      end
      OP_JAL: begin
        rf_wr_en = 1'b1; do_jump = 1'b1; alu_a_sel = 1'b1; alu_b_sel = 1'b1; rf_wr_sel = WB_PC4;
      end
      OP_JALR: begin
        rf_wr_en = 1'b1; do_jump = 1'b1; alu_b_sel = 1'b1; rf_wr_sel = WB_PC4;
      end
      OP_BRANCH: begin
        is_branch = 1'b1; alu_a_sel = 1'b1; alu_b_sel = 1'b1; br_type = br_type_of(funct3);
      end
      OP_LOAD: begin
        rf_wr_en = 1'b1; alu_b_sel = 1'b1; rf_wr_sel = WB_MEM;
        dm_rd_ctrl = (funct3 == 3'b111) ? 3'd0 : 3'(funct3 + 3'd1);
      end
      OP_STORE: begin
        alu_b_sel = 1'b1;
        dm_wr_ctrl = funct3[2] ? 3'd0 : 3'(funct3 + 3'd1);
      end
      OP_IMM: begin
        rf_wr_en = 1'b1; alu_b_sel = 1'b1; rf_wr_sel = WB_ALU;
        alu_ctrl = alu_op(funct3, (funct3 == 3'b101) & inst[30]);
      end
      OP_REG: begin
        rf_wr_en = 1'b1; rf_wr_sel = WB_ALU;
        alu_ctrl = alu_op(funct3, inst[30]);
      end
      OP_SYSTEM: begin
        // ebreak enters debug; other system ops decode as no-ops here
        is_debug = (inst[31:7] == 25'h0002000);
      end
      default: ;
    endcase
  end

endmodule

module idc_decode #(
  parameter int unsigned XLEN = 64
) (
  input  logic [31:0]     instruction_IF,
  input  logic [XLEN-1:0] pc_IFR,
  output idc_bundle_t     bundle
);

  logic [63:0]           imm_full;
  logic                  rf_wr_en, do_jump, is_branch, is_debug, alu_a_sel, alu_b_sel;
  logic [ALU_CTRL_W-1:0] alu_ctrl;
  logic [BR_W-1:0]       br_type;
  logic [WR_SEL_W-1:0]   rf_wr_sel;
  logic [DM_CTRL_W-1:0]  dm_rd_ctrl, dm_wr_ctrl;

  imm u_imm (.inst(instruction_IF), .out(imm_full));

  ctrl u_ctrl (
    .inst       (instruction_IF),
    .rf_wr_en   (rf_wr_en),
    .do_jump    (do_jump),
    .is_branch  (is_branch),
    .is_debug   (is_debug),
    .alu_a_sel  (alu_a_sel),
    .alu_b_sel  (alu_b_sel),
    .alu_ctrl   (alu_ctrl),
    .br_type    (br_type),
    .rf_wr_sel  (rf_wr_sel),
    .dm_rd_ctrl (dm_rd_ctrl),
    .dm_wr_ctrl (dm_wr_ctrl)
  );

  // Pack raw register fields, immediate, pc and control into one bundle
  always_comb begin
    bundle            = IDC_BUBBLE;
    bundle.rd         = instruction_IF[11:7];
    bundle.rs1        = instruction_IF[19:15];
    bundle.rs2        = instruction_IF[24:20];
    bundle.imm        = IDC_XLEN'(imm_full[XLEN-1:0]);
    bundle.pc         = IDC_XLEN'(pc_IFR);
    bundle.rf_wr_en   = rf_wr_en;
    bundle.do_jump    = do_jump;
    bundle.is_branch  = is_branch;
    bundle.is_debug   = is_debug;
    bundle.alu_a_sel  = alu_a_sel;
    bundle.alu_b_sel  = alu_b_sel;
    bundle.alu_ctrl   = alu_ctrl;
    bundle.br_type    = br_type;
    bundle.rf_wr_sel  = rf_wr_sel;
    bundle.dm_rd_ctrl = dm_rd_ctrl;
    bundle.dm_wr_ctrl = dm_wr_ctrl;
  end

endmodule

// File: rtl/pipeline_idc_queue.sv
// DEPTH-entry FIFO of decoded instruction bundles between IF and EX, with
// valid/ready on both sides and a synchronous flush.
// Optional macro PIPELINE_IDC_BYPASS_EN: an empty queue forwards the freshly
// decoded bundle to the outputs in the same cycle.
import pipeline_idc_pkg::*;

module pipeline_idc_queue #(
  parameter  int unsigned XLEN  = 64,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instruction_IF,
  input  logic [XLEN-1:0]       pc_IFR,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_W-1:0]      rd_ID,
  output logic [REG_W-1:0]      rs1_IDC,
  output logic [REG_W-1:0]      rs2_IDC,
  output logic [XLEN-1:0]       imm_ID,
  output logic [XLEN-1:0]       pc_IDC,
  output logic                  rf_wr_en,
  output logic                  do_jump,
  output logic                  is_branch,
  output logic                  is_debug,
  output logic                  alu_a_sel,
  output logic                  alu_b_sel,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic [BR_W-1:0]       BrType,
  output logic [WR_SEL_W-1:0]   rf_wr_sel,
  output logic [DM_CTRL_W-1:0]  dm_rd_ctrl,
  output logic [DM_CTRL_W-1:0]  dm_wr_ctrl,
  output logic [CNT_W-1:0]      count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  idc_bundle_t       dec_bundle;
  idc_bundle_t       head_bundle;
  idc_bundle_t       out_bundle;
  idc_bundle_t       mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              empty, full, do_enq, do_deq;
`ifdef PIPELINE_IDC_BYPASS_EN
  logic              bypass;
`endif

  idc_decode #(.XLEN(XLEN)) u_decode (
    .instruction_IF (instruction_IF),
    .pc_IFR         (pc_IFR),
    .bundle         (dec_bundle)
  );

  // Handshake qualification and head selection; full/empty come from count only
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CNT_W'(DEPTH));
    in_ready = ~full;
`ifdef PIPELINE_IDC_BYPASS_EN
    bypass      = empty & in_valid & ~flush;
    out_valid   = ~empty | bypass;
    head_bundle = bypass ? dec_bundle : mem[rd_ptr];
    do_enq      = in_valid & ~full & ~flush & ~(bypass & out_ready);
    do_deq      = ~empty & out_ready & ~flush;
`else
    out_valid   = ~empty;
    head_bundle = mem[rd_ptr];
    do_enq      = in_valid & ~full & ~flush;
    do_deq      = ~empty & out_ready & ~flush;
`endif
    out_bundle  = out_valid ? head_bundle : IDC_BUBBLE;
  end

  // Pointer and occupancy registers; flush clears them, reset wins over flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_enq) wr_ptr <= PTR_W'(wr_ptr + PTR_W'(1));
      if (do_deq) rd_ptr <= PTR_W'(rd_ptr + PTR_W'(1));
      case ({do_enq, do_deq})
        2'b10:   count_q <= CNT_W'(count_q + CNT_W'(1));
        2'b01:   count_q <= CNT_W'(count_q - CNT_W'(1));
        default: count_q <= count_q;
      endcase
    end
  end

  // Bundle storage; contents are never visible while the slot is unoccupied
  always_ff @(posedge clk) begin
    if (do_enq) mem[wr_ptr] <= dec_bundle;
  end

  assign rd_ID      = out_bundle.rd;
  assign rs1_IDC    = out_bundle.rs1;
  assign rs2_IDC    = out_bundle.rs2;
  assign imm_ID     = out_bundle.imm[XLEN-1:0];
  assign pc_IDC     = out_bundle.pc[XLEN-1:0];
  assign rf_wr_en   = out_bundle.rf_wr_en;
  assign do_jump    = out_bundle.do_jump;
  assign is_branch  = out_bundle.is_branch;
  assign is_debug   = out_bundle.is_debug;
  assign alu_a_sel  = out_bundle.alu_a_sel;
  assign alu_b_sel  = out_bundle.alu_b_sel;
  assign alu_ctrl   = out_bundle.alu_ctrl;
  assign BrType     = out_bundle.br_type;
  assign rf_wr_sel  = out_bundle.rf_wr_sel;
  assign dm_rd_ctrl = out_bundle.dm_rd_ctrl;
  assign dm_wr_ctrl = out_bundle.dm_wr_ctrl;
  assign count      = count_q;

endmodule

// File: tb/tb_pipeline_idc_queue.sv
// Directed bench for pipeline_idc_queue (XLEN=64, DEPTH=2).
module tb_pipeline_idc_queue;

  logic        clk, reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instruction_IF;
  logic [63:0] pc_IFR, imm_ID, pc_IDC;
  logic [4:0]  rd_ID, rs1_IDC, rs2_IDC;
  logic        rf_wr_en, do_jump, is_branch, is_debug, alu_a_sel, alu_b_sel;
  logic [3:0]  alu_ctrl;
  logic [2:0]  BrType, dm_rd_ctrl, dm_wr_ctrl;
  logic [1:0]  rf_wr_sel;
  logic [1:0]  count;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] ADDI_X5_7  = 32'h00700293;  // addi x5,x0,7
  localparam logic [31:0] SW_X6_8_X2 = 32'h00612423;  // sw x6,8(x2)
  localparam logic [31:0] ADDI_X1_M1 = 32'hFFF00093;  // addi x1,x0,-1

  pipeline_idc_queue #(.XLEN(64), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instruction_IF(instruction_IF), .pc_IFR(pc_IFR),
    .out_valid(out_valid), .out_ready(out_ready),
    .rd_ID(rd_ID), .rs1_IDC(rs1_IDC), .rs2_IDC(rs2_IDC),
    .imm_ID(imm_ID), .pc_IDC(pc_IDC),
    .rf_wr_en(rf_wr_en), .do_jump(do_jump), .is_branch(is_branch), .is_debug(is_debug),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_ctrl(alu_ctrl), .BrType(BrType),
    .rf_wr_sel(rf_wr_sel), .dm_rd_ctrl(dm_rd_ctrl), .dm_wr_ctrl(dm_wr_ctrl),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] ins, input logic [63:0] pc);
    in_valid       = 1'b1;
    instruction_IF = ins;
    pc_IFR         = pc;
  endtask

  // Every visible field of the bubble must be zero
  task automatic chk_bubble(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_rd"},    64'(rd_ID),     64'd0);
    chk({tag, "_rs2"},   64'(rs2_IDC),   64'd0);
    chk({tag, "_imm"},   imm_ID,         64'd0);
    chk({tag, "_pc"},    pc_IDC,         64'd0);
    chk({tag, "_wren"},  64'(rf_wr_en),  64'd0);
    chk({tag, "_bsel"},  64'(alu_b_sel), 64'd0);
    chk({tag, "_wbsel"}, 64'(rf_wr_sel), 64'd0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instruction_IF = '0; pc_IFR = '0;
    #3;
    chk("rst_count", 64'(count), 64'd0);
    chk_bubble("rst");
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    chk("rel_count", 64'(count), 64'd0);

    // 1: single addi, then the queue drains back to a bubble
    push(ADDI_X5_7, 64'h8000_0000);
    out_ready = 1'b1;
`ifdef PIPELINE_IDC_BYPASS_EN
    #1;
    chk("t1_byp_valid", 64'(out_valid), 64'd1);
    chk("t1_byp_rd", 64'(rd_ID), 64'd5);
`endif
    tick();
    in_valid = 1'b0;
`ifdef PIPELINE_IDC_BYPASS_EN
    chk("t1_byp_count", 64'(count), 64'd0);
    chk("t1_byp_valid_after", 64'(out_valid), 64'd0);
`else
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_rd",    64'(rd_ID),     64'd5);
    chk("t1_rs1",   64'(rs1_IDC),   64'd0);
    chk("t1_rs2",   64'(rs2_IDC),   64'd7);
    chk("t1_imm",   imm_ID,         64'd7);
    chk("t1_wren",  64'(rf_wr_en),  64'd1);
    chk("t1_bsel",  64'(alu_b_sel), 64'd1);
    chk("t1_alu",   64'(alu_ctrl),  64'd0);
    chk("t1_wbsel", 64'(rf_wr_sel), 64'd1);
    chk("t1_pc",    pc_IDC,         64'h8000_0000);
    chk("t1_count", 64'(count),     64'd1);
    tick();
`endif
    chk("t1_count_end", 64'(count), 64'd0);
    chk_bubble("t1_end");

    // 2: fill to DEPTH with out_ready low, third push refused
    out_ready = 1'b0;
    push(ADDI_X5_7, 64'h0);
    tick();
    chk("t2_count1", 64'(count), 64'd1);
    chk("t2_ready1", 64'(in_ready), 64'd1);
    push(SW_X6_8_X2, 64'h4);
    tick();
    chk("t2_count2", 64'(count), 64'd2);
    chk("t2_ready2", 64'(in_ready), 64'd0);
    push(ADDI_X5_7, 64'h8);
    tick();
    chk("t2_count_full", 64'(count), 64'd2);
    chk("t2_head0_pc", pc_IDC, 64'h0);
    // full with out_ready=1: dequeue happens, the offered 0xC is ignored
    push(ADDI_X5_7, 64'hC);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t2_count_deq", 64'(count), 64'd1);
    chk("t2_head1_pc", pc_IDC, 64'h4);
    chk("t2_sw_rd",   64'(rd_ID),      64'd8);
    chk("t2_sw_rs1",  64'(rs1_IDC),    64'd2);
    chk("t2_sw_rs2",  64'(rs2_IDC),    64'd6);
    chk("t2_sw_imm",  imm_ID,          64'd8);
    chk("t2_sw_wren", 64'(rf_wr_en),   64'd0);
    chk("t2_sw_dmwr", 64'(dm_wr_ctrl), 64'd3);
    tick();
    chk("t2_drained", 64'(count), 64'd0);
    chk("t2_drained_valid", 64'(out_valid), 64'd0);

    // 3: streaming 8 instructions, pointers wrap several times
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(ADDI_X5_7, 64'h100 + 64'(4 * i));
`ifdef PIPELINE_IDC_BYPASS_EN
      #1;
      chk("t3_byp_pc", pc_IDC, 64'h100 + 64'(4 * i));
      tick();
      chk("t3_byp_count", 64'(count), 64'd0);
`else
      tick();
      chk("t3_valid", 64'(out_valid), 64'd1);
      chk("t3_pc", pc_IDC, 64'h100 + 64'(4 * i));
      chk("t3_count", 64'(count), 64'd1);
`endif
    end
    in_valid = 1'b0;
    tick();
    chk("t3_drained", 64'(count), 64'd0);

    // 4: flush a full queue while both handshakes are offered
    out_ready = 1'b0;
    push(ADDI_X1_M1, 64'h200);
    tick();
    chk("t4_neg_imm", imm_ID, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t4_neg_rd", 64'(rd_ID), 64'd1);
    push(ADDI_X5_7, 64'h204);
    tick();
    chk("t4_full", 64'(count), 64'd2);
    push(ADDI_X5_7, 64'h208);
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("t4_count", 64'(count), 64'd0);
    chk("t4_ready", 64'(in_ready), 64'd1);
    chk_bubble("t4");
    tick();
    chk("t4_nothing_written", 64'(count), 64'd0);

    // 5: asynchronous reset between edges with two entries queued
    out_ready = 1'b0;
    push(ADDI_X5_7, 64'h300);
    tick();
    push(ADDI_X5_7, 64'h304);
    tick();
    in_valid = 1'b0;
    chk("t5_full", 64'(count), 64'd2);
    #3;
    reset = 1'b1;
    #1;
    chk("t5_count", 64'(count), 64'd0);
    chk_bubble("t5");
    #1;
    reset = 1'b0;
    #1;
    chk("t5_ready", 64'(in_ready), 64'd1);
    tick();

    // 6: same-cycle visibility depends on the bypass build
    out_ready = 1'b1;
    push(ADDI_X5_7, 64'h400);
    #1;
`ifdef PIPELINE_IDC_BYPASS_EN
    chk("t6_same_valid", 64'(out_valid), 64'd1);
    chk("t6_same_rd", 64'(rd_ID), 64'd5);
    chk("t6_same_count", 64'(count), 64'd0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("t6_after_count", 64'(count), 64'd0);
    chk("t6_after_valid", 64'(out_valid), 64'd0);
`else
    chk("t6_same_valid", 64'(out_valid), 64'd0);
    tick();
    in_valid = 1'b0;
    chk("t6_next_valid", 64'(out_valid), 64'd1);
    chk("t6_next_rd", 64'(rd_ID), 64'd5);
    chk("t6_next_pc", pc_IDC, 64'h400);
    chk("t6_next_count", 64'(count), 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
